// File: rtl/seg_chars_pkg.sv
// Character codes shared by the game-mode blocks and the 7-segment scan driver.
package seg_chars_pkg;

   localparam int unsigned CODE_W     = 5;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 2;
   localparam int unsigned DATA_W     = CODE_W * NUM_DIGITS;

   localparam logic [CODE_W-1:0] C_0      = 5'd0;
   localparam logic [CODE_W-1:0] C_1      = 5'd1;
   localparam logic [CODE_W-1:0] C_2      = 5'd2;
   localparam logic [CODE_W-1:0] C_3      = 5'd3;
   localparam logic [CODE_W-1:0] C_4      = 5'd4;
   localparam logic [CODE_W-1:0] C_5      = 5'd5;
   localparam logic [CODE_W-1:0] C_6      = 5'd6;
   localparam logic [CODE_W-1:0] C_7      = 5'd7;
   localparam logic [CODE_W-1:0] C_8      = 5'd8;
   localparam logic [CODE_W-1:0] C_9      = 5'd9;
   localparam logic [CODE_W-1:0] C_HYPHEN = 5'd10;
   localparam logic [CODE_W-1:0] C_E      = 5'd11;
   localparam logic [CODE_W-1:0] C_r      = 5'd12;
   localparam logic [CODE_W-1:0] C_L      = 5'd13;
   localparam logic [CODE_W-1:0] C_o      = 5'd17;
   localparam logic [CODE_W-1:0] C_b      = 5'd18;
   localparam logic [CODE_W-1:0] C_d      = 5'd19;
   localparam logic [CODE_W-1:0] C_BLANK  = 5'd31;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_ON    = 1'b1
   } phase_e;

endpackage

// File: rtl/seg_char_decoder.sv
// Character code to active-high segment pattern {g..a}; unknown codes stay dark.
module seg_char_decoder
   import seg_chars_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [SEG_W-1:0]  pattern_c_o
);

   always_comb begin
      pattern_c_o = 7'h00;
      case (code_i)
         C_0:      pattern_c_o = 7'h3F;
         C_1:      pattern_c_o = 7'h06;
         C_2:      pattern_c_o = 7'h5B;
         C_3:      pattern_c_o = 7'h4F;
         C_4:      pattern_c_o = 7'h66;
         C_5:      pattern_c_o = 7'h6D;
         C_6:      pattern_c_o = 7'h7D;
         C_7:      pattern_c_o = 7'h07;
         C_8:      pattern_c_o = 7'h7F;
         C_9:      pattern_c_o = 7'h6F;
         C_HYPHEN: pattern_c_o = 7'h40;
         C_E:      pattern_c_o = 7'h79;
         C_r:      pattern_c_o = 7'h50;
         C_L:      pattern_c_o = 7'h38;
         C_o:      pattern_c_o = 7'h5C;
         C_b:      pattern_c_o = 7'h7C;
         C_d:      pattern_c_o = 7'h5E;
         default:  pattern_c_o = 7'h00;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver with per-slot blanking and frame-aligned input capture.
module seg_scan_driver
   import seg_chars_pkg::*;
#(
   parameter int unsigned DIGIT_TICKS = 100_000,
   parameter int unsigned BLANK_TICKS = 1_000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] seg_data,
   input  logic [3:0]        dp_in,
   output logic [3:0]        an,
   output logic [SEG_W-1:0]  seg,
   output logic              dp,
   output logic              frame_tick
);

   localparam int unsigned TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
   localparam logic [TICK_W-1:0] BLANK_LIM = TICK_W'(BLANK_TICKS);

   logic [TICK_W-1:0]                 tick_q, tick_d;
   logic [DIGIT_W-1:0]                digit_q, digit_d;
   logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_data_q, shadow_data_d;
   logic [NUM_DIGITS-1:0]             shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]             an_q, an_d;
   logic [SEG_W-1:0]                  seg_q, seg_d;
   logic                              dp_q, dp_d;
   logic                              frame_tick_q, frame_tick_d;

   phase_e             phase_c;
   logic [CODE_W-1:0]  cur_code_c;
   logic [SEG_W-1:0]   pattern_c;
   logic [NUM_DIGITS-1:0] an_hi_c;
   logic [SEG_W-1:0]   seg_hi_c;
   logic               dp_hi_c;

   assign cur_code_c = shadow_data_q[digit_q];

   seg_char_decoder u_dec (
      .code_i      (cur_code_c),
      .pattern_c_o (pattern_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_q        <= '0;
         digit_q       <= '0;
         shadow_data_q <= {NUM_DIGITS{C_BLANK}};
         shadow_dp_q   <= '0;
         an_q          <= {NUM_DIGITS{ACTIVE_LOW}};
         seg_q         <= {SEG_W{ACTIVE_LOW}};
         dp_q          <= ACTIVE_LOW;
         frame_tick_q  <= 1'b0;
      end else begin
         tick_q        <= tick_d;
         digit_q       <= digit_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_tick_q  <= frame_tick_d;
      end
   end

   // Counters, frame-boundary snapshot and registered pin values for the current slot.
   always_comb begin
      tick_d        = tick_q + TICK_W'(1);
      digit_d       = digit_q;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      frame_tick_d  = 1'b0;
      an_hi_c       = '0;
      seg_hi_c      = '0;
      dp_hi_c       = 1'b0;
      phase_c       = PH_BLANK;

      if (tick_q == TICK_LAST) begin
         tick_d  = '0;
         digit_d = digit_q + DIGIT_W'(1);
         if (digit_q == DIGIT_W'(NUM_DIGITS - 1)) begin
            shadow_data_d = seg_data;
            shadow_dp_d   = dp_in;
            frame_tick_d  = 1'b1;
         end
      end

      if (tick_q >= BLANK_LIM) begin
         phase_c = PH_ON;
      end

      if (phase_c == PH_ON) begin
         an_hi_c[digit_q] = 1'b1;
         seg_hi_c         = pattern_c;
         dp_hi_c          = shadow_dp_q[digit_q];
      end

      an_d  = an_hi_c ^ {NUM_DIGITS{ACTIVE_LOW}};
      seg_d = seg_hi_c ^ {SEG_W{ACTIVE_LOW}};
      dp_d  = dp_hi_c ^ ACTIVE_LOW;
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It consumes the 20-bit packed character word produced by the game-mode blocks (`seg_data`: four 5-bit character codes, digit 3 in bits [19:15], digit 0 in [4:0]). It decodes each code to a segment pattern and scans the digits, with an anti-ghosting blank gap between them. Input is captured only at frame boundaries, so a displayed frame never mixes old and new characters.

## Interface

Parameters:
- `DIGIT_TICKS`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2.
- `BLANK_TICKS`, default 1_000: cycles at the start of each slot with all anodes off. Requires 0 ≤ `BLANK_TICKS` < `DIGIT_TICKS`.
- `ACTIVE_LOW`, default 1: when 1, `an`, `seg` and `dp` are inverted at the pins. When 0, they are active-high.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `seg_data`  in  20  packed character codes, digit 3 MSB … digit 0 LSB.
- `dp_in`  in  4  decimal-point request per digit; bit i belongs to digit i.
- `an`  out  4  digit anodes; bit i drives digit i (digit 0 is rightmost).
- `seg`  out  7  segments; seg[0]=a … seg[6]=g.
- `dp`  out  1  decimal-point segment.
- `frame_tick`  out  1  one-cycle pulse when a new `seg_data`/`dp_in` snapshot takes effect.

## Operation

- **Counters.** `tick_cnt` runs 0..`DIGIT_TICKS`-1 and wraps. `digit_idx` runs 0..3 and advances when `tick_cnt` wraps; 3 wraps to 0.
- **Phase per slot.**
  - BLANK while `tick_cnt` < `BLANK_TICKS`: all anodes off, segments off, dp off.
  - ON otherwise: only `an[digit_idx]` is active, and `seg` shows the decoded shadow code for that digit.
- **Shadow registers.** 20-bit `shadow_data` and 4-bit `shadow_dp`.
  - Loaded from `seg_data`/`dp_in` on the cycle where `digit_idx`==3 and `tick_cnt`==`DIGIT_TICKS`-1 (the frame boundary).
  - Changes to `seg_data`/`dp_in` at any other time have no visible effect until the next boundary.
- **Character decode.** Active-high pattern, listed as hex {g..a}:
  - Digits: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Letters: 10 `-`→40, 11 `E`→79, 12 `r`→50, 13 `L`→38, 17 `o`→5C, 18 `b`→7C, 19 `d`→5E.
  - 31 blank→00.
  - Codes 14–16 and 20–30 are undefined and decode to 00 (blank). They must never produce a lit segment.
- **Polarity.** With `ACTIVE_LOW`=1, the pins are the bitwise inverse of the active-high values. An all-off output is then `an`=4'hF, `seg`=7'h7F, `dp`=1.
- **Reset** (synchronous, takes priority over everything):
  - `tick_cnt`=0, `digit_idx`=0.
  - `shadow_data`={5'd31 ×4} (all blank), `shadow_dp`=0.
  - All outputs at their off level; `frame_tick`=0.
  - Reset asserted mid-slot or mid-frame abandons that frame. The scan restarts at digit 0, BLANK phase, on the first cycle after reset is released.
- **First frame after reset** shows nothing, because the shadow is blank. The first input snapshot is taken at the end of that frame.

## Timing

- **Latency.** `an`/`seg`/`dp`/`frame_tick` are registered, one cycle after the counter state that produces them.
- **Outputs during reset.** In every cycle with `reset` high, and in the first cycle after release, all outputs are off.
- **`frame_tick`.** High for exactly one cycle: the cycle after the boundary load, i.e. when `digit_idx`=0 and `tick_cnt`=0 are first presented. Period is 4·`DIGIT_TICKS` cycles.
- **Digit slots.** With `BLANK_TICKS`=B and `DIGIT_TICKS`=D, each digit's anode is active for D−B consecutive cycles per frame. Its window is offset by one cycle from the counter.
- **No overlap.** At most one anode is active in any cycle, and never during BLANK. With B=0 there is no gap, but there is still never more than one anode active.

## Structure

- **Shared package** `seg_chars_pkg`: the character-code localparams (C_BLANK=31, C_HYPHEN=10, C_E=11, C_r=12, C_L=13, C_o=17, C_b=18, C_d=19, digits 0–9). The game-mode blocks and this driver use the same definitions.
- **Sub-module** `seg_char_decoder`: purely combinational, 5-bit code in, 7-bit active-high pattern out. It is instantiated once, on the muxed shadow digit.
- **Top level** holds the counters, shadow registers, phase logic and output registers.

## Test plan

All scenarios use `DIGIT_TICKS`=8, `BLANK_TICKS`=2, `ACTIVE_LOW`=1.

1. **Reset and first frame.** Hold `reset` 3 cycles with `seg_data`=1234 codes, then release. Required: `an`=F, `seg`=7F, `dp`=1 throughout reset and the whole first frame (32 cycles). `frame_tick` pulses once, at cycle 33 after release.
2. **Steady display of "1234".** In the second frame, `an`=E for cycles 3–8 of slot 0 with `seg`=~66=19. Then `an`=D with `seg`=~4F=30, `an`=B with `seg`=~5B=24, `an`=7 with `seg`=~06=79. Cycles 1–2 of each slot are all-off.
3. **Tear-free update.** Change `seg_data` to {10,11,12,12} ("-Err") midway through digit 1 of frame 2. Frame 2 still shows 1234. Frame 3 digit 0 shows `seg`=~50=2F and digit 3 shows ~40=3F.
4. **Decoder sweep.** Codes gogo, good, LOSE, and undefined codes 14, 20, 30: the patterns match the table, and the undefined codes give `seg`=7F with the anode still active.
5. **`dp_in`.** `dp_in`=4'b0100 gives `dp`=0 only during digit 2's ON window. The change takes effect at the next `frame_tick`.
6. **Reset mid-frame.** Assert `reset` 1 cycle during digit 2's ON window. Required: outputs off on the following cycle, shadow blank, and scan restarting at digit 0. The next `frame_tick` comes exactly 33 cycles after the reset cycle.
